// File: rtl/keylock_pkg.sv
// rtl/keylock_pkg.sv - shared arbiter state encoding, width defaults and blink presets
package keylock_pkg;

    localparam int TIME_W_DEF = 32;
    localparam int REPS_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } arb_state_t;

    // Blink presets in hwclk cycles at 12 MHz
    localparam logic [31:0] ERR_ON   = 32'd12_000_000;
    localparam logic [31:0] ERR_OFF  = 32'd6_000_000;
    localparam logic [7:0]  ERR_REPS = 8'd3;
    localparam logic [31:0] OK_ON    = 32'd2_400_000;
    localparam logic [31:0] OK_OFF   = 32'd2_400_000;
    localparam logic [7:0]  OK_REPS  = 8'd3;

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational lowest-index-wins one-hot selector
module prio_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant
);

    // Two's complement isolates the lowest set bit
    assign o_grant = i_req & (-i_req);

endmodule

// File: rtl/pattern_arbiter.sv
// rtl/pattern_arbiter.sv - fixed-priority arbiter sharing one blink-pattern generator
module pattern_arbiter
    import keylock_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIME_W  = TIME_W_DEF,
    parameter int REPS_W  = REPS_W_DEF,
    parameter int PREEMPT = 1
) (
    input  logic                     hwclk,
    input  logic                     resetN,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*TIME_W-1:0]   req_ontime,
    input  logic [NREQ*TIME_W-1:0]   req_offtime,
    input  logic [NREQ*REPS_W-1:0]   req_reps,
    output logic [NREQ-1:0]          ack,
    output logic [NREQ-1:0]          abort,
    output logic                     busy,
    output logic [NREQ-1:0]          owner,
    output logic [TIME_W-1:0]        pat_ontime,
    output logic [TIME_W-1:0]        pat_offtime,
    output logic [REPS_W-1:0]        pat_reps,
    output logic                     pat_enable,
    input  logic                     pat_done,
    input  logic                     pat_bright,
    output logic [NREQ-1:0]          led_out
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [NREQ-1:0]   r_owner;
    logic [NREQ-1:0]   w_pick;
    logic [TIME_W-1:0] r_ontime;
    logic [TIME_W-1:0] r_offtime;
    logic [REPS_W-1:0] r_reps;
    logic [TIME_W-1:0] w_sel_on;
    logic [TIME_W-1:0] w_sel_off;
    logic [REPS_W-1:0] w_sel_reps;
    logic              w_preempt;

    prio_pick #(.N(NREQ)) u_pick (
        .i_req   (req),
        .o_grant (w_pick)
    );

    always_comb begin
        w_sel_on   = '0;
        w_sel_off  = '0;
        w_sel_reps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_sel_on   = req_ontime[i*TIME_W +: TIME_W];
                w_sel_off  = req_offtime[i*TIME_W +: TIME_W];
                w_sel_reps = req_reps[i*REPS_W +: REPS_W];
            end
        end
    end

    assign w_preempt = (PREEMPT != 0) && req[0] && !r_owner[0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|req) w_next = ST_LOAD;
            ST_LOAD:  w_next = (r_reps == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                // A completing pattern is acked even if req[0] arrives together
                if (pat_done)       w_next = ST_DONE;
                else if (w_preempt) w_next = ST_ABORT;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (!resetN) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ontime  <= '0;
            r_offtime <= '0;
            r_reps    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && (|req)) begin
                r_owner   <= w_pick;
                r_ontime  <= w_sel_on;
                r_offtime <= w_sel_off;
                r_reps    <= w_sel_reps;
            end else if (r_state == ST_DONE || r_state == ST_ABORT) begin
                r_owner <= '0;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign owner       = r_owner;
    assign pat_enable  = (r_state == ST_RUN);
    assign ack         = (r_state == ST_DONE)  ? r_owner : '0;
    assign abort       = (r_state == ST_ABORT) ? r_owner : '0;
    assign led_out     = (r_state == ST_RUN && pat_bright) ? r_owner : '0;
    assign pat_ontime  = r_ontime;
    assign pat_offtime = r_offtime;
    assign pat_reps    = r_reps;

endmodule

// File: tb/tb_pattern_arbiter.sv
// tb/tb_pattern_arbiter.sv - directed bench for pattern_arbiter with pulse scoreboard
module tb_pattern_arbiter;
    import keylock_pkg::*;

    logic        hwclk = 1'b0;
    logic        resetN;
    logic [2:0]  req;
    logic [95:0] cfg_on, cfg_off;
    logic [23:0] cfg_reps;

    // Index 0: PREEMPT=1 instance, index 1: PREEMPT=0 instance
    logic [2:0]  ack [2];
    logic [2:0]  abort [2];
    logic [2:0]  owner [2];
    logic [2:0]  led [2];
    logic [31:0] pon [2];
    logic [31:0] poff [2];
    logic [7:0]  preps [2];
    logic [1:0]  busy, en;
    logic [1:0]  gdone = '0;
    logic [1:0]  gbright;
    logic [31:0] gcnt [2];
    logic [31:0] grep [2];

    int n_tests = 0;
    int n_fail = 0;
    logic [5:0] sb_q [$];
    logic [5:0] sb_exp;
    bit sb_en = 1'b0;
    bit led_chk = 1'b0;
    int led_bad = 0;
    int bright_cnt = 0;
    int abort_b_cnt = 0;
    int rise_cnt [2] = '{0, 0};
    logic [1:0] en_prev = '0;

    always #5 hwclk = ~hwclk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        pattern_arbiter #(
            .NREQ(3), .TIME_W(32), .REPS_W(8), .PREEMPT(k == 0 ? 1 : 0)
        ) u_dut (
            .hwclk       (hwclk),
            .resetN      (resetN),
            .req         (req),
            .req_ontime  (cfg_on),
            .req_offtime (cfg_off),
            .req_reps    (cfg_reps),
            .ack         (ack[k]),
            .abort       (abort[k]),
            .busy        (busy[k]),
            .owner       (owner[k]),
            .pat_ontime  (pon[k]),
            .pat_offtime (poff[k]),
            .pat_reps    (preps[k]),
            .pat_enable  (en[k]),
            .pat_done    (gdone[k]),
            .pat_bright  (gbright[k]),
            .led_out     (led[k])
        );
    end

    // Behavioural blink generator: on for ontime, off for offtime, reps times, then done level
    always @(posedge hwclk) begin
        for (int k = 0; k < 2; k++) begin
            if (en[k] !== 1'b1) begin
                gcnt[k]  <= 0;
                grep[k]  <= 0;
                gdone[k] <= 1'b0;
            end else if (!gdone[k]) begin
                if (gcnt[k] + 1 >= pon[k] + poff[k]) begin
                    gcnt[k] <= 0;
                    if (grep[k] + 1 >= {24'd0, preps[k]}) gdone[k] <= 1'b1;
                    else grep[k] <= grep[k] + 1;
                end else begin
                    gcnt[k] <= gcnt[k] + 1;
                end
            end
        end
    end

    always_comb begin
        gbright = '0;
        for (int k = 0; k < 2; k++)
            gbright[k] = (en[k] === 1'b1) && !gdone[k] && (gcnt[k] < pon[k]);
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tk();
        @(posedge hwclk);
        #1;
    endtask

    task automatic set_cfg(input int i, input logic [31:0] on, input logic [31:0] off,
                           input logic [7:0] reps);
        cfg_on[i*32 +: 32]  = on;
        cfg_off[i*32 +: 32] = off;
        cfg_reps[i*8 +: 8]  = reps;
    endtask

    task automatic wait_ack(input int k, input int b);
        int n = 0;
        while (ack[k][b] !== 1'b1 && n < 300) begin
            tk();
            n++;
        end
        check("wait_ack_bound", 64'(n < 300), 64'd1);
    endtask

    task automatic wait_en(input int k);
        int n = 0;
        while (en[k] !== 1'b1 && n < 300) begin
            tk();
            n++;
        end
        check("wait_en_bound", 64'(n < 300), 64'd1);
    endtask

    task automatic do_reset(input bit sb_after);
        sb_en  = 1'b0;
        resetN = 1'b0;
        req    = '0;
        tk();
        tk();
        resetN = 1'b1;
        tk();
        sb_en  = sb_after;
    endtask

    always @(negedge hwclk) begin
        for (int k = 0; k < 2; k++) begin
            if (en[k] === 1'b1 && en_prev[k] !== 1'b1) rise_cnt[k]++;
            en_prev[k] = en[k];
        end
        if (abort[1] !== 3'b000) abort_b_cnt++;
        if (led_chk) begin
            if (led[0] !== (gbright[0] ? 3'b010 : 3'b000)) led_bad++;
            if (led[0][1] === 1'b1) bright_cnt++;
        end
        if (sb_en && (ack[0] !== 3'b000 || abort[0] !== 3'b000)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pulse", {58'd0, abort[0], ack[0]}, 64'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sb_pulse", {58'd0, abort[0], ack[0]}, {58'd0, sb_exp});
            end
        end
    end

    initial begin
        int done_c, ack_c, n, rc;
        resetN = 1'b0;
        req = '0;
        cfg_on = '0;
        cfg_off = '0;
        cfg_reps = '0;
        tk();
        tk();
        check("rst_busy", busy[0], 0);
        check("rst_owner", owner[0], 0);
        check("rst_enable", en[0], 0);
        check("rst_led", led[0], 0);
        check("rst_ontime", pon[0], 0);
        resetN = 1'b1;
        tk();
        sb_en = 1'b1;

        // Single request from requester 1
        set_cfg(1, 4, 2, 3);
        sb_q.push_back(6'b000_010);
        req = 3'b010;
        led_chk = 1'b1;
        tk();
        check("t1_owner", owner[0], 3'b010);
        check("t1_enable_load", en[0], 0);
        tk();
        check("t1_enable_rise", en[0], 1);
        cfg_on[63:32] = 32'd99;
        tk();
        check("t1_cfg_held", pon[0], 4);
        done_c = -1;
        ack_c = -1;
        n = 0;
        while (ack_c < 0 && n < 300) begin
            tk();
            n++;
            if (gdone[0] && done_c < 0) done_c = n;
            if (ack[0][1] === 1'b1) ack_c = n;
        end
        check("t1_ack_after_done", 64'(ack_c), 64'(done_c + 1));
        tk();
        req = '0;
        led_chk = 1'b0;
        tk();
        check("t1_idle_owner", owner[0], 0);
        check("t1_idle_busy", busy[0], 0);
        check("t1_led_mirror", 64'(led_bad), 0);
        check("t1_bright_cycles", 64'(bright_cnt), 12);

        // Simultaneous requests 1 and 2
        set_cfg(1, 3, 1, 1);
        set_cfg(2, 2, 2, 2);
        sb_q.push_back(6'b000_010);
        sb_q.push_back(6'b000_100);
        req = 3'b110;
        tk();
        check("t2_first_owner", owner[0], 3'b010);
        wait_ack(0, 1);
        check("t2_done_enable_low", en[0], 0);
        tk();
        req = 3'b100;
        check("t2_gap_idle_enable", en[0], 0);
        tk();
        check("t2_second_owner", owner[0], 3'b100);
        check("t2_gap_load_enable", en[0], 0);
        tk();
        check("t2_second_rise", en[0], 1);
        wait_ack(0, 2);
        tk();
        req = '0;
        tk();

        // Preemption with PREEMPT=1
        set_cfg(2, 20, 2, 2);
        set_cfg(0, 2, 1, 1);
        sb_q.push_back(6'b100_000);
        sb_q.push_back(6'b000_001);
        sb_q.push_back(6'b000_100);
        req = 3'b100;
        wait_en(0);
        tk();
        tk();
        tk();
        req = 3'b101;
        tk();
        check("t3_abort_pulse", abort[0], 3'b100);
        check("t3_abort_enable", en[0], 0);
        tk();
        check("t3_idle_owner", owner[0], 0);
        tk();
        check("t3_req0_owner", owner[0], 3'b001);
        wait_ack(0, 0);
        tk();
        req = 3'b100;
        tk();
        check("t3_reserve_owner", owner[0], 3'b100);
        check("t3_reserve_ontime", pon[0], 20);
        wait_ack(0, 2);
        tk();
        req = '0;
        tk();
        check("t3_sb_drained", 64'(sb_q.size()), 0);

        // Same stimulus on the PREEMPT=0 instance
        do_reset(1'b0);
        abort_b_cnt = 0;
        req = 3'b100;
        wait_en(1);
        tk();
        tk();
        tk();
        req = 3'b101;
        tk();
        check("t4_no_abort", abort[1], 0);
        check("t4_keeps_running", en[1], 1);
        check("t4_keeps_owner", owner[1], 3'b100);
        wait_ack(1, 2);
        tk();
        req = 3'b001;
        tk();
        check("t4_req0_after", owner[1], 3'b001);
        wait_ack(1, 0);
        tk();
        req = '0;
        check("t4_abort_count", 64'(abort_b_cnt), 0);
        do_reset(1'b1);

        // reps=0 goes LOAD to DONE without enabling
        set_cfg(1, ERR_ON, ERR_OFF, 0);
        rc = rise_cnt[0];
        sb_q.push_back(6'b000_010);
        req = 3'b010;
        tk();
        check("t5_owner", owner[0], 3'b010);
        check("t5_ontime", pon[0], ERR_ON);
        check("t5_offtime", poff[0], ERR_OFF);
        tk();
        check("t5_ack", ack[0], 3'b010);
        check("t5_enable_low", en[0], 0);
        tk();
        req = '0;
        tk();
        check("t5_no_enable_rise", 64'(rise_cnt[0]), 64'(rc));
        check("t5_idle", busy[0], 0);

        // Reset mid-RUN, then re-grant with re-latched config
        set_cfg(1, 4, 2, OK_REPS);
        req = 3'b010;
        tk();
        tk();
        tk();
        check("t6_running", en[0], 1);
        resetN = 1'b0;
        tk();
        check("t6_rst_busy", busy[0], 0);
        check("t6_rst_owner", owner[0], 0);
        check("t6_rst_enable", en[0], 0);
        check("t6_rst_ack_abort", {ack[0], abort[0]}, 0);
        check("t6_rst_led", led[0], 0);
        check("t6_rst_cfg", {pon[0], poff[0], preps[0]}, 0);
        set_cfg(1, OK_ON, OK_OFF, OK_REPS);
        resetN = 1'b1;
        tk();
        check("t6_regrant_owner", owner[0], 3'b010);
        check("t6_relatch_on", pon[0], OK_ON);
        check("t6_relatch_off", poff[0], OK_OFF);
        check("t6_relatch_reps", preps[0], OK_REPS);
        tk();
        check("t6_regrant_enable", en[0], 1);
        do_reset(1'b0);

        check("sb_final_empty", 64'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
